// File: rtl/mem_access_m.sv
// Memory-stage data-access controller: turns M-stage load/store requests into a
// valid/ready memory transaction, stalls the pipeline while it is in flight, and extends load data.
module mem_access_m #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int BE_WIDTH     = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [FUNCT3_WIDTH-1:0] funct3M,
    input  logic [DATA_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    StallM,
    output logic                    MisalignM,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [DATA_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [BE_WIDTH-1:0]     mem_req_be,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);
    localparam int OFF_W = $clog2(BE_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [FUNCT3_WIDTH-1:0] f3_q, f3_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    access, is_byte, is_half, is_word;
    logic                    code_ok, misalign, illegal, legal;
    logic [OFF_W-1:0]        off;
    logic [BE_WIDTH-1:0]     be_new;
    logic [DATA_WIDTH-1:0]   wdata_new;
    logic [DATA_WIDTH-1:0]   lane, ext;

    assign off = ALUResultM[OFF_W-1:0];

    // Request decode: legality, byte enables and lane-replicated store data.
    always_comb begin
        access  = MemReadM | MemWriteM;
        is_byte = (funct3M[1:0] == 2'b00);
        is_half = (funct3M[1:0] == 2'b01);
        is_word = (funct3M[1:0] == 2'b10);
        case (funct3M)
            3'b000, 3'b001, 3'b010: code_ok = 1'b1;
            3'b100, 3'b101:         code_ok = ~MemWriteM;
            default:                code_ok = 1'b0;
        endcase
        misalign = (is_half & off[0]) | (is_word & (off != '0));
        illegal  = access & ((MemReadM & MemWriteM) | ~code_ok | misalign);
        legal    = access & ~illegal;

        be_new    = '1;
        wdata_new = WriteDataM;
        if (is_byte) begin
            be_new    = BE_WIDTH'(1) << off;
            wdata_new = {BE_WIDTH{WriteDataM[7:0]}};
        end else if (is_half) begin
            be_new    = BE_WIDTH'(3) << {off[OFF_W-1:1], 1'b0};
            wdata_new = {(BE_WIDTH/2){WriteDataM[15:0]}};
        end
    end

    // Load extension uses the offset/size latched with the request, not the live inputs.
    always_comb begin
        lane = mem_rsp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: ext = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    addr_d  = {ALUResultM[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    we_d    = MemWriteM;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = funct3M;
                    off_d   = off;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = ext;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    // DONE drops the stall so the pipeline advances exactly once per access.
    assign StallM        = ((state_q == IDLE) & legal) | (state_q == REQ) | (state_q == WAIT);
    assign MisalignM     = illegal;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;
    assign ReadDataM     = rdata_q;
endmodule

// File: tb/tb_mem_access_m.sv
// Randomized self-checking bench for mem_access_m against an arithmetic model of
// the byte-lane, extension, legality and latency rules.
module tb_mem_access_m;
    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, MisalignM;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] rd_model;

    mem_access_m dut (
        .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 CLK = ~CLK;

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int s = size_of(f3);
        int o = int'(addr[1:0]);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + s) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int s = size_of(f3);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % s))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int s = size_of(f3);
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        logic [31:0] v = (rdata >> (8 * int'(addr[1:0]))) & mask;
        if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        #1;
        n_chk++;
        if ({mem_req_valid, mem_req_we, StallM, MisalignM} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {mem_req_valid, mem_req_we, StallM, MisalignM});
        end
        n_chk++;
        if ({mem_req_addr, mem_req_wdata, mem_req_be, ReadDataM} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h be %b rd %h exp 0", mem_req_addr, mem_req_wdata, mem_req_be, ReadDataM);
        end
        rd_model = 32'h0;
    endtask

    // Legal access with ready delayed rdly valid cycles and response delayed sdly WAIT cycles.
    task automatic run_legal(input string nm, input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata, input int rdly, input int sdly);
        int nstall = 0, nvalid = 0, nwait = 0, exp_stall;
        bit hs = 0, got = 0, done = 0;
        logic [31:0] exp_addr = {addr[31:2], 2'b00};
        exp_stall = rd ? (3 + rdly + sdly) : (2 + rdly);
        if (rd) rd_model = ref_load(f3, addr, rdata);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge CLK); #1;
            MemReadM = rd; MemWriteM = !rd; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
            mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
            if (mem_req_valid) begin
                mem_req_ready = (nvalid >= rdly);
                mem_rsp_valid = 1'($urandom_range(0, 1));
            end else if (hs && rd && !got) begin
                mem_rsp_valid = (nwait >= sdly);
                if (mem_rsp_valid) begin mem_rsp_rdata = rdata; got = 1; end
                nwait++;
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (cyc == 0) begin
                n_chk++;
                if (MisalignM !== 1'b0) begin n_fail++; $display("FAIL %s misalign: got %b exp 0", nm, MisalignM); end
            end
            if (mem_req_valid) begin
                nvalid++;
                n_chk++;
                if ({mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata} !== {!rd, exp_addr, ref_be(f3, addr), rd ? mem_req_wdata : ref_wdata(f3, wd)}) begin
                    n_fail++;
                    $display("FAIL %s req: got we %b addr %h be %b wdata %h exp we %b addr %h be %b wdata %h", nm,
                             mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata, !rd, exp_addr, ref_be(f3, addr), ref_wdata(f3, wd));
                end
                if (mem_req_ready) hs = 1;
            end
            if (StallM) nstall++;
            else done = 1;
        end
        n_chk++;
        if (!done) begin n_fail++; $display("FAIL %s timeout: stall never dropped", nm); end
        n_chk++;
        if (nstall != exp_stall) begin n_fail++; $display("FAIL %s stall_cycles: got %0d exp %0d", nm, nstall, exp_stall); end
        n_chk++;
        if (nvalid != rdly + 1) begin n_fail++; $display("FAIL %s valid_cycles: got %0d exp %0d", nm, nvalid, rdly + 1); end
        n_chk++;
        if (ReadDataM !== rd_model) begin n_fail++; $display("FAIL %s rdata: got %h exp %h", nm, ReadDataM, rd_model); end
        @(posedge CLK); #1;
        idle_inputs();
        #1;
        n_chk++;
        if ({StallM, mem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL %s post_idle: got %b exp 00", nm, {StallM, mem_req_valid}); end
    endtask

    task automatic test_illegal(input string nm, input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge CLK); #1;
            MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = $urandom;
            mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = $urandom;
            #1;
            n_chk++;
            if ({MisalignM, StallM, mem_req_valid} !== 3'b100) begin
                n_fail++; $display("FAIL %s flags: got mis/stall/valid %b exp 100", nm, {MisalignM, StallM, mem_req_valid});
            end
            n_chk++;
            if (ReadDataM !== rd_model) begin n_fail++; $display("FAIL %s rdata_hold: got %h exp %h", nm, ReadDataM, rd_model); end
        end
        @(posedge CLK); #1 idle_inputs();
    endtask

    task automatic test_directed();
        run_legal("lw", 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        n_chk++;
        if (ReadDataM !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_const: got %h exp deadbeef", ReadDataM); end
        run_legal("lb", 1, 3'b000, 32'h203, 0, 32'h80FF1234, 0, 0);
        n_chk++;
        if (ReadDataM !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_const: got %h exp ffffff80", ReadDataM); end
        run_legal("lbu", 1, 3'b100, 32'h203, 0, 32'h80FF1234, 0, 1);
        n_chk++;
        if (ReadDataM !== 32'h00000080) begin n_fail++; $display("FAIL lbu_const: got %h exp 00000080", ReadDataM); end
        run_legal("lh", 1, 3'b001, 32'h202, 0, 32'h80FF1234, 1, 0);
        n_chk++;
        if (ReadDataM !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_const: got %h exp ffff80ff", ReadDataM); end
        run_legal("lhu", 1, 3'b101, 32'h202, 0, 32'h80FF1234, 0, 0);
        n_chk++;
        if (ReadDataM !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_const: got %h exp 000080ff", ReadDataM); end
        run_legal("sb", 0, 3'b000, 32'h301, 32'h000000AB, 0, 3, 0);
        run_legal("sh", 0, 3'b001, 32'h402, 32'h00001234, 0, 0, 0);
        n_chk++;
        if ({mem_req_be, mem_req_wdata} !== {4'b1100, 32'h12341234}) begin
            n_fail++; $display("FAIL sh_const: got be %b wdata %h exp 1100 12341234", mem_req_be, mem_req_wdata);
        end
    endtask

    task automatic test_illegal_cases();
        test_illegal("lw_mis", 1, 0, 3'b010, 32'h101);
        test_illegal("sh_mis", 0, 1, 3'b001, 32'h403);
        test_illegal("ld_f3_011", 1, 0, 3'b011, 32'h100);
        test_illegal("st_f3_100", 0, 1, 3'b100, 32'h100);
        test_illegal("rd_and_wr", 1, 1, 3'b010, 32'h100);
    endtask

    task automatic test_random();
        logic [2:0] ld_codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] st_codes[3] = '{3'b000, 3'b001, 3'b010};
        for (int n = 0; n < 40; n++) begin
            bit rd = 1'($urandom_range(0, 1));
            logic [2:0] f3 = rd ? ld_codes[$urandom_range(0, 4)] : st_codes[$urandom_range(0, 2)];
            logic [31:0] addr = $urandom & ~(32'(size_of(f3)) - 32'd1);
            run_legal("rand", rd, f3, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        run_legal("lw_pre", 1, 3'b010, 32'h500, 0, 32'hCAFEF00D, 0, 0);
        @(posedge CLK); #1;
        MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h600;
        @(posedge CLK); #1 mem_req_ready = 1;
        #1;
        n_chk++;
        if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got valid %b exp 1", mem_req_valid); end
        @(posedge CLK); #1;
        mem_req_ready = 0; MemReadM = 0; RST = 1;
        #1;
        n_chk++;
        if (StallM !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait: got stall %b exp 1", StallM); end
        @(posedge CLK); #1;
        RST = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
        #1;
        rd_model = 32'h0;
        n_chk++;
        if ({StallM, mem_req_valid, ReadDataM} !== {2'b00, 32'h0}) begin
            n_fail++; $display("FAIL rst_mid_idle: got stall %b valid %b rd %h exp 0 0 0", StallM, mem_req_valid, ReadDataM);
        end
        @(posedge CLK); #1 mem_rsp_valid = 0;
        #1;
        n_chk++;
        if ({StallM, ReadDataM} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL rst_mid_stray: got stall %b rd %h exp 0 0", StallM, ReadDataM);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal_cases();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
